// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/video block-RAM arbiter.
//   port_id_t        : requester encoding, also the bit index into eligible/grant vectors
//   MEM_RD_LAT       : registered read latency of the block RAM, in cycles
//   OWNER_PIPE_DEPTH : depth of the read-owner pipe that tracks reads in flight
//   rd_slot_t        : one owner-pipe entry {valid, owner}
package mem_arbiter_pkg;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_VID = 1'b1
  } port_id_t;

  localparam int unsigned MEM_RD_LAT       = 1;
  localparam int unsigned OWNER_PIPE_DEPTH = MEM_RD_LAT + 1;

  typedef struct packed {
    logic     valid;
    port_id_t owner;
  } rd_slot_t;

  // One-hot grant (bit 0 = CPU, bit 1 = video) to port id.
  function automatic port_id_t grant_to_port(logic [1:0] grant);
    return grant[1] ? PORT_VID : PORT_CPU;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU, video and block-RAM signals around the arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives acks, read data, RAM port)
//   master : environment view (CPU, video fetcher and RAM drive the other side)
// Parameters: AW address width, DW data width.
interface mem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
) ();

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;
  logic          vid_ack;

  logic [AW-1:0] mem_address;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    output cpu_rdata, cpu_ack, vid_rdata, vid_ack, mem_address, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    input  cpu_rdata, cpu_ack, vid_rdata, vid_ack, mem_address, mem_we, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
//   eligible   : per-port request-and-not-busy (bit 0 = CPU, bit 1 = video)
//   last_grant : port granted most recently
//   grant      : one-hot winner, or zero when nothing is eligible
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] eligible,
  input  port_id_t   last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = eligible;
    // On a tie the port that did not win last time goes first.
    if (eligible == 2'b11) begin
      grant = (last_grant == PORT_VID) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port block RAM between the CPU and the video fetcher.
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : CPU request/ack, video request/ack and the registered RAM port
// Writes ack one cycle after grant (alongside mem_we); reads ack two cycles after grant,
// when the RAM's registered read data is on mem_rdata.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  // The ack flop loads from AckStage so the ack lands in the cycle RetStage holds the read.
  localparam int unsigned AckStage = OWNER_PIPE_DEPTH - 2;
  localparam int unsigned RetStage = OWNER_PIPE_DEPTH - 1;

  logic [1:0]    eligible;
  logic [1:0]    grant;
  logic          grant_any;
  logic          cpu_wr_grant;
  logic          ret_cpu;
  logic          ret_vid;

  port_id_t      last_grant_q;
  logic          cpu_busy_q;
  logic          vid_busy_q;
  rd_slot_t      rd_pipe_q [OWNER_PIPE_DEPTH];
  logic [AW-1:0] mem_address_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_wdata_q;
  logic          cpu_ack_q;
  logic          vid_ack_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] vid_rdata_q;

  // A port with a transaction in flight is never re-granted.
  assign eligible = {bus.vid_req & ~vid_busy_q, bus.cpu_req & ~cpu_busy_q};

  rr_arb2 u_rr_arb2 (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    grant_any    = |grant;
    cpu_wr_grant = grant[0] & bus.cpu_we;
    ret_cpu      = rd_pipe_q[RetStage].valid && (rd_pipe_q[RetStage].owner == PORT_CPU);
    ret_vid      = rd_pipe_q[RetStage].valid && (rd_pipe_q[RetStage].owner == PORT_VID);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q  <= PORT_VID;
      cpu_busy_q    <= 1'b0;
      vid_busy_q    <= 1'b0;
      for (int i = 0; i < OWNER_PIPE_DEPTH; i++) begin
        rd_pipe_q[i] <= '{valid: 1'b0, owner: PORT_CPU};
      end
      mem_address_q <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      cpu_ack_q     <= 1'b0;
      vid_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      vid_rdata_q   <= '0;
    end else begin
      if (grant_any) begin
        last_grant_q  <= grant_to_port(grant);
        mem_address_q <= grant[0] ? bus.cpu_addr : bus.vid_addr;
        if (grant[0]) begin
          mem_wdata_q <= bus.cpu_wdata;
        end
      end
      mem_we_q <= cpu_wr_grant;

      rd_pipe_q[0].valid <= grant_any & ~cpu_wr_grant;
      rd_pipe_q[0].owner <= grant_to_port(grant);
      for (int i = 1; i < OWNER_PIPE_DEPTH; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end

      cpu_ack_q <= cpu_wr_grant |
                   (rd_pipe_q[AckStage].valid && (rd_pipe_q[AckStage].owner == PORT_CPU));
      vid_ack_q <= rd_pipe_q[AckStage].valid && (rd_pipe_q[AckStage].owner == PORT_VID);

      // Busy drops at the end of the ack cycle; grant and ack never coincide on one port.
      cpu_busy_q <= (cpu_busy_q & ~cpu_ack_q) | grant[0];
      vid_busy_q <= (vid_busy_q & ~vid_ack_q) | grant[1];

      if (ret_cpu) begin
        cpu_rdata_q <= bus.mem_rdata;
      end
      if (ret_vid) begin
        vid_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // RAM data arrives in the ack cycle itself, so it is forwarded then and held afterwards.
  assign bus.cpu_rdata   = ret_cpu ? bus.mem_rdata : cpu_rdata_q;
  assign bus.vid_rdata   = ret_vid ? bus.mem_rdata : vid_rdata_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.vid_ack     = vid_ack_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected acks (cycle + data) into per-port
// queues, a negedge monitor pops and compares whenever an ack is seen.
module tb_mem_arbiter;

  typedef struct {
    int         cyc;
    bit         rd;
    logic [7:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   passes = 0;
  int   t;

  exp_t exp_cpu [$];
  exp_t exp_vid [$];
  exp_t mon_cpu;
  exp_t mon_vid;

  bit   [7:0]  ram [65536];
  logic [15:0] exp_addr [9] = '{16'h0010, 16'h8000, 16'h8000, 16'h0010, 16'h8000,
                                16'h8000, 16'h0010, 16'h8000, 16'h8000};
  logic [7:0]  vid_data [4] = '{8'h5A, 8'h11, 8'h12, 8'h13};

  mem_arbiter_if #(.AW(16), .DW(8)) bus ();

  mem_arbiter #(.AW(16), .DW(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Block RAM model: one-cycle registered read, write on mem_we.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.mem_we) ram[bus.mem_address] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_address];
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_cpu(int c, bit rd, logic [7:0] d);
    exp_cpu.push_back('{c, rd, d});
  endtask

  task automatic push_vid(int c, logic [7:0] d);
    exp_vid.push_back('{c, 1'b1, d});
  endtask

  // Monitor: every ack must match the head of its queue in cycle and data.
  always @(negedge clock) begin
    if (bus.cpu_ack) begin
      check("cpu_ack_expected", 32'(exp_cpu.size() != 0), 1);
      if (exp_cpu.size() != 0) begin
        mon_cpu = exp_cpu.pop_front();
        check("cpu_ack_cycle", cyc, mon_cpu.cyc);
        if (mon_cpu.rd) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(mon_cpu.data));
      end
    end
    if (bus.vid_ack) begin
      check("vid_ack_expected", 32'(exp_vid.size() != 0), 1);
      if (exp_vid.size() != 0) begin
        mon_vid = exp_vid.pop_front();
        check("vid_ack_cycle", cyc, mon_vid.cyc);
        check("vid_rdata", 32'(bus.vid_rdata), 32'(mon_vid.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    ram[16'h0010] = 8'h3C;
    for (int i = 0; i < 4; i++) ram[16'h8000 + 16'(i)] = vid_data[i];

    // Reset values.
    tick(); tick();
    @(negedge clock);
    check("rst_mem_address", 32'(bus.mem_address), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check("rst_cpu_ack", 32'(bus.cpu_ack), 0);
    check("rst_vid_ack", 32'(bus.vid_ack), 0);
    check("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    check("rst_vid_rdata", 32'(bus.vid_rdata), 0);
    tick();
    reset = 1'b0;

    // CPU write 0xA5 -> 0x1234.
    tick(); t = cyc;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h1234; bus.cpu_wdata = 8'hA5;
    push_cpu(t + 1, 1'b0, 8'h00);
    tick(); @(negedge clock);
    check("wr_mem_address", 32'(bus.mem_address), 32'h1234);
    check("wr_mem_we", 32'(bus.mem_we), 1);
    check("wr_mem_wdata", 32'(bus.mem_wdata), 32'hA5);
    check("wr_cpu_ack", 32'(bus.cpu_ack), 1);
    bus.cpu_req = 1'b0;
    tick(); @(negedge clock);
    check("wr_mem_we_drop", 32'(bus.mem_we), 0);

    // CPU read back 0x1234.
    tick(); t = cyc;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    push_cpu(t + 2, 1'b1, 8'hA5);
    tick(); @(negedge clock);
    check("rd_no_early_ack", 32'(bus.cpu_ack), 0);
    tick(); @(negedge clock);
    bus.cpu_req = 1'b0;

    // Contention from reset release: CPU 0x0010, video 0x8000, both reading.
    tick();
    reset = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
    bus.vid_req = 1'b1; bus.vid_addr = 16'h8000;
    tick();
    reset = 1'b0; t = cyc;
    for (int i = 0; i < 3; i++) begin
      push_cpu(t + 2 + 3 * i, 1'b1, 8'h3C);
      push_vid(t + 3 + 3 * i, 8'h5A);
    end
    for (int k = 1; k <= 9; k++) begin
      tick(); @(negedge clock);
      check($sformatf("cont_addr_c%0d", k), 32'(bus.mem_address), 32'(exp_addr[k-1]));
      if (k == 8) bus.cpu_req = 1'b0;
      if (k == 9) bus.vid_req = 1'b0;
    end

    // Video back-to-back with the address stepping on each ack.
    tick(); t = cyc;
    bus.vid_req = 1'b1; bus.vid_addr = 16'h8000;
    for (int i = 0; i < 4; i++) push_vid(t + 2 + 3 * i, vid_data[i]);
    for (int i = 0; i < 4; i++) begin
      tick(); tick(); @(negedge clock);
      if (i == 3) bus.vid_req = 1'b0;
      else bus.vid_addr = 16'h8000 + 16'(i + 1);
      tick();
    end

    // Reset one cycle after a CPU read grant: no ack, everything back to reset values.
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
    tick();
    reset = 1'b1;
    tick(); @(negedge clock);
    check("mid_rst_cpu_ack", 32'(bus.cpu_ack), 0);
    check("mid_rst_vid_ack", 32'(bus.vid_ack), 0);
    check("mid_rst_mem_we", 32'(bus.mem_we), 0);
    check("mid_rst_mem_address", 32'(bus.mem_address), 0);
    check("mid_rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check("mid_rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    check("mid_rst_vid_rdata", 32'(bus.vid_rdata), 0);
    bus.vid_req = 1'b1; bus.vid_addr = 16'h8000;
    tick();
    reset = 1'b0; t = cyc;
    push_cpu(t + 2, 1'b1, 8'hA5);
    push_vid(t + 3, 8'h5A);
    tick(); @(negedge clock);
    check("post_rst_cpu_wins_tie", 32'(bus.mem_address), 32'h1234);
    tick(); @(negedge clock);
    bus.cpu_req = 1'b0;
    tick(); @(negedge clock);
    bus.vid_req = 1'b0;

    // Video read granted, then CPU write next cycle: both ack together.
    tick(); t = cyc;
    bus.vid_req = 1'b1; bus.vid_addr = 16'h8002;
    push_vid(t + 2, 8'h12);
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0020; bus.cpu_wdata = 8'h77;
    push_cpu(t + 2, 1'b0, 8'h00);
    tick(); @(negedge clock);
    check("sim_cpu_ack", 32'(bus.cpu_ack), 1);
    check("sim_vid_ack", 32'(bus.vid_ack), 1);
    bus.cpu_req = 1'b0; bus.vid_req = 1'b0;

    // Read back the write from the simultaneous-completion case.
    tick(); t = cyc;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0020;
    push_cpu(t + 2, 1'b1, 8'h77);
    tick(); tick(); @(negedge clock);
    bus.cpu_req = 1'b0;

    repeat (4) tick();
    @(negedge clock);
    check("cpu_queue_drained", 32'(exp_cpu.size()), 0);
    check("vid_queue_drained", 32'(exp_vid.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
